// File: rtl/lcd_cmd_arb.sv
// Two-requester arbiter and sequencer for the 17-bit LCD SPI frame transmitter.
// Define LCD_CMD_ARB_RR_EN for round-robin arbitration; default is fixed priority (req0 first).
module lcd_cmd_arb #(
  parameter int PRESCALER       = 100,
  parameter int SHORT_GAP_TICKS = PRESCALER * 50,
  parameter int LONG_GAP_TICKS  = PRESCALER * 2000,
  parameter int BUSY_TIMEOUT    = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  req0_word,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [9:0]  req1_word,
  input  logic        req1_valid,
  output logic        req1_ready,
  output logic [16:0] spi_din,
  output logic        spi_vin,
  input  logic        spi_busy,
  output logic        grant_id,
  output logic        idle,
  output logic        err
);

  localparam int CW = $clog2(LONG_GAP_TICKS + 1);
  localparam logic [CW-1:0] LONG_LAST  = CW'(LONG_GAP_TICKS - 1);
  localparam logic [CW-1:0] SHORT_LAST = CW'(SHORT_GAP_TICKS - 1);
  localparam logic [CW-1:0] TMO_LAST   = CW'(BUSY_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_RISE,
    WAIT_FALL,
    GAP
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          long_gap;
  logic          sel1;
  logic          accept;
  logic [9:0]    word_sel;
  logic [CW-1:0] gap_last;

`ifdef LCD_CMD_ARB_RR_EN
  logic ptr;
  assign sel1 = req1_valid && (!req0_valid || ptr);
`else
  assign sel1 = !req0_valid;
`endif

  assign req0_ready = !rst && (state == IDLE) && req0_valid && !sel1;
  assign req1_ready = !rst && (state == IDLE) && req1_valid && sel1;
  assign accept     = req0_ready || req1_ready;
  assign word_sel   = sel1 ? req1_word : req0_word;
  assign gap_last   = long_gap ? LONG_LAST : SHORT_LAST;
  assign idle       = (state == IDLE);

  // Clear display (0x01) and return home (0x02/0x03) need the long execution time.
  function automatic logic is_long(input logic [9:0] w);
    return !w[9] && (w[7:2] == 6'd0) && (w[1:0] != 2'd0);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      spi_din  <= '0;
      spi_vin  <= 1'b0;
      grant_id <= 1'b0;
      err      <= 1'b0;
      cnt      <= '0;
      long_gap <= 1'b0;
`ifdef LCD_CMD_ARB_RR_EN
      ptr      <= 1'b0;
`endif
    end else begin
      spi_vin <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            spi_din  <= {6'b111110, word_sel, 1'b1};
            spi_vin  <= 1'b1;
            grant_id <= sel1;
            long_gap <= is_long(word_sel);
            cnt      <= '0;
`ifdef LCD_CMD_ARB_RR_EN
            ptr      <= !sel1;
`endif
            state    <= START;
          end
        end
        START: begin
          // cnt counts cycles since the strobe for the busy timeout
          cnt   <= cnt + 1'b1;
          state <= WAIT_RISE;
        end
        WAIT_RISE: begin
          if (spi_busy) begin
            state <= WAIT_FALL;
          end else if (cnt == TMO_LAST) begin
            err   <= 1'b1;
            cnt   <= '0;
            state <= GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_FALL: begin
          if (!spi_busy) begin
            cnt   <= '0;
            state <= GAP;
          end
        end
        GAP: begin
          if (cnt == gap_last) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_cmd_arb.sv
// Randomized scoreboard bench for lcd_cmd_arb with a queue-level arbitration model.
// Gap parameters are scaled down so long gaps fit a short run.
`timescale 1ns/1ps
module tb_lcd_cmd_arb;

  localparam int PRESC = 2;
  localparam int SHORT = PRESC * 50;
  localparam int LONG  = PRESC * 2000;
  localparam int TMO   = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  req0_word = '0;
  logic        req0_valid = 1'b0;
  logic        req0_ready;
  logic [9:0]  req1_word = '0;
  logic        req1_valid = 1'b0;
  logic        req1_ready;
  logic [16:0] spi_din;
  logic        spi_vin;
  logic        spi_busy = 1'b0;
  logic        grant_id;
  logic        idle;
  logic        err;

  lcd_cmd_arb #(
    .PRESCALER(PRESC),
    .SHORT_GAP_TICKS(SHORT),
    .LONG_GAP_TICKS(LONG),
    .BUSY_TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req0_word(req0_word),
    .req0_valid(req0_valid),
    .req0_ready(req0_ready),
    .req1_word(req1_word),
    .req1_valid(req1_valid),
    .req1_ready(req1_ready),
    .spi_din(spi_din),
    .spi_vin(spi_vin),
    .spi_busy(spi_busy),
    .grant_id(grant_id),
    .idle(idle),
    .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       id;
    logic [9:0] word;
    bit         lng;
  } exp_t;

  exp_t       sb[$];
  logic [9:0] q0[$];
  logic [9:0] q1[$];
  logic [9:0] s0[$];
  logic [9:0] s1[$];
  bit         ptr_m = 1'b0;
  bit         tmo_mode = 1'b0;
  bit         err_exp = 1'b0;
  int         rise_dly = 2;
  int         busy_len = 10;

  function automatic bit is_clr_home(input logic [9:0] w);
    return (w == 10'h001) || (w == 10'h002) || (w == 10'h003);
  endfunction

  function automatic logic [9:0] rand_word();
    logic [7:0] d;
    d = 8'($urandom);
    if ($urandom_range(0, 3) == 0) return {2'b00, 8'h80 | d};
    return {2'b10, d};
  endfunction

  // Both staged queues present valid together and hold it until drained,
  // so the grant order follows from the queues alone.
  task automatic issue();
    int  i0;
    int  i1;
    bit  pick;
    i0 = 0;
    i1 = 0;
    while (i0 < s0.size() || i1 < s1.size()) begin
      if (i0 >= s0.size()) pick = 1'b1;
      else if (i1 >= s1.size()) pick = 1'b0;
      else begin
`ifdef LCD_CMD_ARB_RR_EN
        pick = ptr_m;
`else
        pick = 1'b0;
`endif
      end
      if (pick) begin
        sb.push_back('{1'b1, s1[i1], is_clr_home(s1[i1])});
        i1++;
      end else begin
        sb.push_back('{1'b0, s0[i0], is_clr_home(s0[i0])});
        i0++;
      end
      ptr_m = !pick;
    end
    foreach (s0[i]) q0.push_back(s0[i]);
    foreach (s1[i]) q1.push_back(s1[i]);
    s0.delete();
    s1.delete();
  endtask

  // Requester drivers: hold word and valid until accepted.
  initial forever begin
    bit take;
    @(negedge clk);
    take = req0_valid && req0_ready;
    @(posedge clk);
    #1;
    if (take && q0.size() != 0) void'(q0.pop_front());
    req0_valid = (q0.size() != 0) && !rst;
    req0_word  = (q0.size() != 0) ? q0[0] : 10'($urandom);
  end

  initial forever begin
    bit take;
    @(negedge clk);
    take = req1_valid && req1_ready;
    @(posedge clk);
    #1;
    if (take && q1.size() != 0) void'(q1.pop_front());
    req1_valid = (q1.size() != 0) && !rst;
    req1_word  = (q1.size() != 0) ? q1[0] : 10'($urandom);
  end

  // Transmitter model
  initial forever begin
    @(negedge clk);
    if (spi_vin && !rst && !tmo_mode) begin
      for (int i = 0; i < rise_dly && !rst; i++) @(posedge clk);
      #1;
      if (!rst) spi_busy = 1'b1;
      for (int i = 0; i < busy_len && !rst; i++) @(posedge clk);
      #1;
      spi_busy = 1'b0;
    end
  end

  always @(posedge rst) spi_busy = 1'b0;

  // Monitor
  int   cyc = 0;
  bit   track = 1'b0;
  bit   acc_p = 1'b0;
  bit   saw_busy = 1'b0;
  bit   cur_long = 1'b0;
  int   acc_cyc = 0;
  int   vin_cyc = 0;
  int   gap_ref = -1;
  exp_t e;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      track   = 1'b0;
      acc_p   = 1'b0;
      err_exp = 1'b0;
    end else begin
      if (req0_ready || req1_ready) begin
        chk("ready_excl", idle && (req0_ready ^ req1_ready), 1);
`ifndef LCD_CMD_ARB_RR_EN
        chk("fixed_prio", req0_valid && req1_ready, 0);
`endif
      end
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
        acc_p   = 1'b1;
        acc_cyc = cyc;
      end
      if (track && cyc == vin_cyc + 1) chk("vin_one_cycle", spi_vin, 0);
      if (spi_vin) begin
        chk("vin_latency", acc_p && (cyc == acc_cyc + 1), 1);
        acc_p = 1'b0;
        chk("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("spi_din", spi_din, {6'b111110, e.word, 1'b1});
          chk("grant_id", grant_id, e.id);
          track    = 1'b1;
          vin_cyc  = cyc;
          cur_long = e.lng;
          saw_busy = 1'b0;
          gap_ref  = -1;
        end
      end else if (track) begin
        if (gap_ref < 0) begin
          if (tmo_mode) begin
            if (cyc == vin_cyc + TMO - 1) chk("err_before_tmo", err, 0);
            if (cyc == vin_cyc + TMO) begin
              chk("err_at_tmo", err, 1);
              err_exp = 1'b1;
              gap_ref = cyc;
            end
          end else if (!saw_busy) begin
            if (spi_busy) saw_busy = 1'b1;
          end else if (!spi_busy) begin
            // the FSM sees the fall at the next edge
            gap_ref = cyc + 1;
          end
        end
        if (idle) begin
          chk("idle_return", cyc, gap_ref + (cur_long ? LONG : SHORT));
          chk("err_sticky", err, err_exp);
          track = 1'b0;
        end
      end
    end
  end

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || q0.size() != 0 || q1.size() != 0 || track || !idle) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk(name, n < 20000, 1);
    @(negedge clk);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_spi_vin", spi_vin, 0);
    chk("rst_spi_din", spi_din, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_err", err, 0);
    chk("rst_idle", idle, 1);
    chk("rst_ready", {req0_ready, req1_ready}, 0);
    @(posedge clk);
    #2 rst = 1'b0;

    rise_dly = 2;
    busy_len = 40;
    s0.push_back(10'h241);
    issue();
    wait_done("single_done");

    busy_len = 12;
    s0.push_back(10'h001);
    s1.push_back(rand_word());
    s1.push_back(rand_word());
    issue();
    wait_done("clear_done");

    s0.push_back(10'h002);
    issue();
    wait_done("home_done");
    s1.push_back(10'h003);
    issue();
    wait_done("home1_done");

    for (int i = 0; i < 4; i++) begin
      s0.push_back(rand_word());
      s1.push_back(rand_word());
    end
    issue();
    wait_done("contention_done");

    for (int i = 0; i < 3; i++) s0.push_back(rand_word());
    s1.push_back(rand_word());
    issue();
    wait_done("backpressure_done");

    for (int p = 0; p < 8; p++) begin
      rise_dly = $urandom_range(1, 6);
      busy_len = $urandom_range(1, 30);
      for (int i = 0; i < int'($urandom_range(0, 3)); i++) s0.push_back(rand_word());
      for (int i = 0; i < int'($urandom_range(0, 3)); i++) s1.push_back(rand_word());
      issue();
      wait_done("random_done");
    end

    @(posedge clk);
    #1 spi_busy = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_ignores_busy", idle, 1);
    @(posedge clk);
    #1 spi_busy = 1'b0;
    @(negedge clk);

    tmo_mode = 1'b1;
    s1.push_back(rand_word());
    issue();
    wait_done("timeout_done");
    tmo_mode = 1'b0;
    repeat (10) @(negedge clk);
    chk("err_held", err, 1);

    rise_dly = 2;
    busy_len = 40;
    s0.push_back(rand_word());
    issue();
    n = 0;
    while (!spi_busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("busy_seen", spi_busy, 1);
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midrst_spi_vin", spi_vin, 0);
    chk("midrst_ready", {req0_ready, req1_ready}, 0);
    chk("midrst_err", err, 0);
    ptr_m = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", idle, 1);
    s1.push_back(rand_word());
    issue();
    wait_done("after_rst_done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
